// File: rtl/dsp_arith_pkg.sv
// Shared arithmetic constants and helpers for the segmented add/sub datapaths.
// Pure declarations, no logic. Optional macro: SUB3P_SATURATE_EN (adds one stage to sub3p).
// Lane widths, lane split helper and sub3p latency for alignment delays.
package dsp_arith_pkg;

    localparam int W_LSB   = 9;
    localparam int W_MID   = 9;
    localparam int W_MSB   = 10;
    localparam int W_TOTAL = W_LSB + W_MID + W_MSB;

`ifdef SUB3P_SATURATE_EN
    localparam int SUB3P_LATENCY = 5;
`else
    localparam int SUB3P_LATENCY = 4;
`endif

    typedef enum logic [1:0] {
        LANE_LSB = 2'd0,
        LANE_MID = 2'd1,
        LANE_MSB = 2'd2
    } lane_e;

    // Lowest bit index of a lane inside the full-width word.
    function automatic int lane_lo(input lane_e lane, input int w1, input int w2);
        case (lane)
            LANE_LSB: return 0;
            LANE_MID: return w1;
            default:  return w1 + w2;
        endcase
    endfunction

endpackage

// File: rtl/sub_lane.sv
// One lane of the segmented subtractor: registered {bout, d} = a - b - bin.
// Latency 1 clk.
// No backpressure, loads every cycle.
module sub_lane #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W:0]   q
);

    logic [W:0] q_nxt;

    // The extra top bit goes to 1 exactly when the lane result is negative.
    always_comb begin
        q_nxt = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/sub3p.sv
// Three-stage segmented-borrow unsigned subtractor, diff = x - y, plus valid chain.
// Latency SUB3P_LATENCY (4, or 5 with SUB3P_SATURATE_EN clamping negative results to 0).
// No backpressure: the pipeline advances every clock.
module sub3p
    import dsp_arith_pkg::*;
#(
    parameter int WIDTH  = W_TOTAL,
    parameter int WIDTH1 = W_LSB,
    parameter int WIDTH2 = W_MID,
    parameter int WIDTH3 = W_MSB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             valid_out,
    output logic             borrow_out,
    output logic             LSBs_borrow,
    output logic             MSBs_borrow
);

    localparam int WIDTH12 = WIDTH1 + WIDTH2;
    localparam int LO_MID  = lane_lo(LANE_MID, WIDTH1, WIDTH2);
    localparam int LO_MSB  = lane_lo(LANE_MSB, WIDTH1, WIDTH2);

    // Stage 0: input registers
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_r <= '0;
            y_r <= '0;
        end else begin
            x_r <= x;
            y_r <= y;
        end
    end

    // Stage 1: independent lane subtracts
    logic [WIDTH1:0] s1_lsb;
    logic [WIDTH2:0] s1_mid;
    logic [WIDTH3:0] s1_msb;

    sub_lane #(.W(WIDTH1)) u_s1_lsb (
        .clk   (clk),
        .reset (reset),
        .a     (x_r[0 +: WIDTH1]),
        .b     (y_r[0 +: WIDTH1]),
        .bin   (1'b0),
        .q     (s1_lsb)
    );

    sub_lane #(.W(WIDTH2)) u_s1_mid (
        .clk   (clk),
        .reset (reset),
        .a     (x_r[LO_MID +: WIDTH2]),
        .b     (y_r[LO_MID +: WIDTH2]),
        .bin   (1'b0),
        .q     (s1_mid)
    );

    sub_lane #(.W(WIDTH3)) u_s1_msb (
        .clk   (clk),
        .reset (reset),
        .a     (x_r[LO_MSB +: WIDTH3]),
        .b     (y_r[LO_MSB +: WIDTH3]),
        .bin   (1'b0),
        .q     (s1_msb)
    );

    assign LSBs_borrow = s1_lsb[WIDTH1];

    // Stage 2: LSB borrow into middle, stage-1 middle borrow into MSB
    logic [WIDTH1-1:0] s2_lsb;
    logic [WIDTH2:0]   s2_mid;
    logic [WIDTH3:0]   s2_msb;
    logic              s2_msb_bor;

    sub_lane #(.W(WIDTH2)) u_s2_mid (
        .clk   (clk),
        .reset (reset),
        .a     (s1_mid[WIDTH2-1:0]),
        .b     ('0),
        .bin   (s1_lsb[WIDTH1]),
        .q     (s2_mid)
    );

    sub_lane #(.W(WIDTH3)) u_s2_msb (
        .clk   (clk),
        .reset (reset),
        .a     (s1_msb[WIDTH3-1:0]),
        .b     ('0),
        .bin   (s1_mid[WIDTH2]),
        .q     (s2_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_lsb     <= '0;
            s2_msb_bor <= 1'b0;
        end else begin
            s2_lsb     <= s1_lsb[WIDTH1-1:0];
            s2_msb_bor <= s1_msb[WIDTH3];
        end
    end

    assign MSBs_borrow = s2_mid[WIDTH2];

    // Stage 3: second middle borrow into MSB
    logic [WIDTH1-1:0] s3_lsb;
    logic [WIDTH2-1:0] s3_mid;
    logic [WIDTH3:0]   s3_msb;
    logic              s3_msb_bor;

    sub_lane #(.W(WIDTH3)) u_s3_msb (
        .clk   (clk),
        .reset (reset),
        .a     (s2_msb[WIDTH3-1:0]),
        .b     ('0),
        .bin   (s2_mid[WIDTH2]),
        .q     (s3_msb)
    );

    // The MSB lane can borrow at most once across the three subtracts, so OR is exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_lsb     <= '0;
            s3_mid     <= '0;
            s3_msb_bor <= 1'b0;
        end else begin
            s3_lsb     <= s2_lsb;
            s3_mid     <= s2_mid[WIDTH2-1:0];
            s3_msb_bor <= s2_msb_bor | s2_msb[WIDTH3];
        end
    end

    logic [WIDTH-1:0] diff_s3;
    logic             bor_s3;

    assign diff_s3 = {s3_msb[WIDTH3-1:0], s3_mid, s3_lsb};
    assign bor_s3  = s3_msb_bor | s3_msb[WIDTH3];

`ifdef SUB3P_SATURATE_EN
    logic [WIDTH-1:0] diff_s4;
    logic             bor_s4;

    always_ff @(posedge clk) begin
        if (reset) begin
            diff_s4 <= '0;
            bor_s4  <= 1'b0;
        end else begin
            diff_s4 <= bor_s3 ? '0 : diff_s3;
            bor_s4  <= bor_s3;
        end
    end

    assign diff       = diff_s4;
    assign borrow_out = bor_s4;
`else
    assign diff       = diff_s3;
    assign borrow_out = bor_s3;
`endif

    // Valid shift chain, one bit per register stage.
    logic [SUB3P_LATENCY-1:0] vld_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[SUB3P_LATENCY-2:0], valid_in};
        end
    end

    assign valid_out = vld_sr[SUB3P_LATENCY-1];

endmodule

// File: tb/tb_sub3p.sv
// Bench for sub3p: vector table, corner sequences and random stream against a queue scoreboard.
module tb_sub3p;
    import dsp_arith_pkg::*;

    localparam int W   = 28;
    localparam int LAT = SUB3P_LATENCY;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic [W-1:0] diff;
    logic         valid_out;
    logic         borrow_out;
    logic         LSBs_borrow;
    logic         MSBs_borrow;

    sub3p dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .x           (x),
        .y           (y),
        .diff        (diff),
        .valid_out   (valid_out),
        .borrow_out  (borrow_out),
        .LSBs_borrow (LSBs_borrow),
        .MSBs_borrow (MSBs_borrow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        int           due;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] d;
        logic         b;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] sat(input logic [W-1:0] d, input logic b);
`ifdef SUB3P_SATURATE_EN
        return b ? '0 : d;
`else
        return (b === 1'bx) ? d : d;
`endif
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [W-1:0] ed, input logic eb);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_in = v;
        x        = xv;
        y        = yv;
        if (v) begin
            exp_t e;
            e.d   = sat(ed, eb);
            e.b   = eb;
            e.due = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic drive_model(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv);
        drive(v, xv, yv, xv - yv, xv < yv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Output monitor: every valid_out must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid_out=1 with nothing expected (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("diff", diff, mon_e.d);
                chk("borrow_out", borrow_out, mon_e.b);
                chk("latency_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: valid_out=%b, expected a result due at cycle %0d (cycle %0d)",
                     valid_out, sb[0].due, cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{28'h0000200, 28'h0000001, 28'h00001FF, 1'b0};
        tbl[1]  = '{28'h0040000, 28'h0000001, 28'h003FFFF, 1'b0};
        tbl[2]  = '{28'h0000005, 28'h0000007, 28'hFFFFFFE, 1'b1};
        tbl[3]  = '{28'h000000A, 28'h0000003, 28'h0000007, 1'b0};
        tbl[4]  = '{28'h0000000, 28'h0000000, 28'h0000000, 1'b0};
        tbl[5]  = '{28'hFFFFFFF, 28'h0000001, 28'hFFFFFFE, 1'b0};
        tbl[6]  = '{28'h0000001, 28'h0000002, 28'hFFFFFFF, 1'b1};
        tbl[7]  = '{28'h0000000, 28'hFFFFFFF, 28'h0000001, 1'b1};
        tbl[8]  = '{28'h1234567, 28'h1234567, 28'h0000000, 1'b0};
        tbl[9]  = '{28'h8000000, 28'h0000001, 28'h7FFFFFF, 1'b0};
        tbl[10] = '{28'h0000100, 28'h8000000, 28'h8000100, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff", diff, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_borrow_out", borrow_out, 0);
        chk("rst_lsbs_borrow", LSBs_borrow, 0);
        chk("rst_msbs_borrow", MSBs_borrow, 0);

        idle(2);
        foreach (tbl[i]) drive(1'b1, tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].b);
        idle(LAT + 2);

        // Lane borrow test bits
        drive(1'b1, tbl[0].x, tbl[0].y, tbl[0].d, tbl[0].b);
        idle(1);
        chk("lsbs_borrow_edge1", LSBs_borrow, 0);
        idle(1);
        chk("lsbs_borrow_edge2", LSBs_borrow, 1);
        idle(1);
        chk("msbs_borrow_no_ripple", MSBs_borrow, 0);
        idle(LAT);

        drive(1'b1, tbl[1].x, tbl[1].y, tbl[1].d, tbl[1].b);
        idle(2);
        chk("lsbs_borrow_ripple", LSBs_borrow, 1);
        chk("msbs_borrow_edge2", MSBs_borrow, 0);
        idle(1);
        chk("msbs_borrow_ripple", MSBs_borrow, 1);
        idle(LAT);

        // Back-to-back stream with a one-cycle gap
        drive(1'b1, tbl[3].x, tbl[3].y, tbl[3].d, tbl[3].b);
        drive(1'b1, tbl[4].x, tbl[4].y, tbl[4].d, tbl[4].b);
        drive(1'b0, 28'h0000123, 28'h0000456, '0, 1'b0);
        drive(1'b1, tbl[5].x, tbl[5].y, tbl[5].d, tbl[5].b);
        drive(1'b1, tbl[6].x, tbl[6].y, tbl[6].d, tbl[6].b);
        idle(LAT + 2);

        // Reset with three samples in flight, valid_in high during reset
        drive_model(1'b1, 28'h0000031, 28'h0000011);
        drive_model(1'b1, 28'h0000002, 28'h0000009);
        drive_model(1'b1, 28'h0ABCDEF, 28'h0012345);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b1;
        x        = 28'h0000009;
        y        = 28'h0000004;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, '0, 1'b0);
            chk("post_rst_valid_out", valid_out, 0);
            chk("post_rst_diff", diff, 0);
        end
        drive_model(1'b1, 28'h0000064, 28'h0000019);
        idle(LAT + 2);

        // Random stream against the reference model
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] rx, ry;
            logic         rv;
            rx = W'($urandom);
            ry = W'($urandom);
            case ($urandom_range(0, 7))
                0: ry = rx;
                1: rx = '0;
                2: ry = ALL1;
                3: ry = rx + W'(1);
                default: ;
            endcase
            rv = ($urandom_range(0, 3) != 0);
            drive_model(rv, rx, ry);
        end
        idle(LAT + 2);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
